// File: rtl/wave_pkg.sv
// Shared definitions for the DDS tone source: waveform mode encodings and default widths.
package wave_pkg;

    localparam int DEF_RESOLUTION_BITS = 8;
    localparam int DEF_ACC_WIDTH       = 16;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_RSVD   = 2'b11
    } wave_mode_t;

endpackage

// File: rtl/dds_wave_gen_if.sv
// Control/sample bundle between a controller (master) and dds_wave_gen (slave).
interface dds_wave_gen_if
    import wave_pkg::*;
#(
    parameter int RESOLUTION_BITS = DEF_RESOLUTION_BITS,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH
);
    logic                       enable;
    logic                       load;
    logic [ACC_WIDTH-1:0]       tuning_word;
    logic [RESOLUTION_BITS-1:0] duty;
    logic [1:0]                 mode;
    logic [RESOLUTION_BITS-1:0] wave_out;
    logic                       wrap;
    logic                       pending;

    modport master (
        output enable, load, tuning_word, duty, mode,
        input  wave_out, wrap, pending
    );

    modport slave (
        input  enable, load, tuning_word, duty, mode,
        output wave_out, wrap, pending
    );
endinterface

// File: rtl/phase_accumulator.sv
// Phase accumulator: adds the active tuning word each enabled cycle, flags the carry-out
// combinationally for the apply logic and as a registered one-cycle wrap pulse.
module phase_accumulator #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic [ACC_WIDTH-1:0] i_tw,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic                 o_carry,
    output logic                 o_wrap
);
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_wrap;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_tw};
    // Carry only counts when the accumulator actually advances this cycle.
    assign o_carry = i_enable & w_sum[ACC_WIDTH];
    assign o_acc   = r_acc;
    assign o_wrap  = r_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
        end else if (i_enable) begin
            r_acc  <= w_sum[ACC_WIDTH-1:0];
            r_wrap <= w_sum[ACC_WIDTH];
        end else begin
            r_wrap <= 1'b0;
        end
    end
endmodule

// File: rtl/dds_wave_gen.sv
// DDS tone source with double-buffered settings applied only at period boundaries.
// Optional feature macro: WAVE_TRIANGLE_EN enables the triangle waveform for mode 10.
module dds_wave_gen
    import wave_pkg::*;
#(
    parameter int RESOLUTION_BITS = DEF_RESOLUTION_BITS,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    dds_wave_gen_if.slave  bus
);
    localparam int R = RESOLUTION_BITS;

    logic [ACC_WIDTH-1:0] r_tw_a;
    logic [R-1:0]         r_duty_a;
    wave_mode_t           r_mode_a;
    logic [ACC_WIDTH-1:0] r_tw_p;
    logic [R-1:0]         r_duty_p;
    wave_mode_t           r_mode_p;
    logic                 r_pending;
    logic [R-1:0]         r_wave;

    logic [ACC_WIDTH-1:0] w_acc;
    logic                 w_carry;
    logic                 w_wrap;
    logic                 w_apply;
    logic [R-1:0]         w_phase;
    logic [R-1:0]         w_wave_next;

    phase_accumulator #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_phase_acc (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_tw     (r_tw_a),
        .o_acc    (w_acc),
        .o_carry  (w_carry),
        .o_wrap   (w_wrap)
    );

    // A frozen phase (disabled or zero step) has no boundary to wait for, so apply at once.
    assign w_apply = r_pending & (w_carry | ~bus.enable | (r_tw_a == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tw_a    <= '0;
            r_duty_a  <= '0;
            r_mode_a  <= MODE_SQUARE;
            r_tw_p    <= '0;
            r_duty_p  <= '0;
            r_mode_p  <= MODE_SQUARE;
            r_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_tw_a   <= r_tw_p;
                r_duty_a <= r_duty_p;
                r_mode_a <= r_mode_p;
            end
            if (bus.load) begin
                r_tw_p    <= bus.tuning_word;
                r_duty_p  <= bus.duty;
                r_mode_p  <= wave_mode_t'(bus.mode);
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_phase = w_acc[ACC_WIDTH-1 -: R];

`ifdef WAVE_TRIANGLE_EN
    logic [R-1:0] w_tri;
    assign w_tri = {w_phase[R-2:0], 1'b0};
`endif

    always_comb begin
        w_wave_next = '0;
        case (r_mode_a)
            MODE_SQUARE: w_wave_next = (w_phase < r_duty_a) ? '1 : '0;
            MODE_SAW:    w_wave_next = w_phase;
`ifdef WAVE_TRIANGLE_EN
            MODE_TRI:    w_wave_next = w_phase[R-1] ? ~w_tri : w_tri;
`else
            MODE_TRI:    w_wave_next = '0;
`endif
            default:     w_wave_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wave <= '0;
        end else begin
            r_wave <= w_wave_next;
        end
    end

    assign bus.wave_out = r_wave;
    assign bus.wrap     = w_wrap;
    assign bus.pending  = r_pending;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: table-driven sawtooth/update sequence plus hand sequences.
module tb_dds_wave_gen;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    dds_wave_gen_if #(.RESOLUTION_BITS(8), .ACC_WIDTH(16)) bus ();

    dds_wave_gen #(
        .RESOLUTION_BITS (8),
        .ACC_WIDTH       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] tw;
        logic [7:0]  duty;
        logic [1:0]  mode;
        logic [7:0]  ew;
        logic        ewrap;
        logic        ep;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] tri_exp [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic ld, input logic [15:0] tw,
                         input logic [7:0] duty, input logic [1:0] mode);
        bus.enable      = en;
        bus.load        = ld;
        bus.tuning_word = tw;
        bus.duty        = duty;
        bus.mode        = mode;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0, 8'h0, 2'b00);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic void addv(input logic en, input logic ld, input logic [15:0] tw,
                                 input logic [7:0] duty, input logic [1:0] mode,
                                 input logic [7:0] ew, input logic ewrap, input logic ep);
        vq.push_back('{en, ld, tw, duty, mode, ew, ewrap, ep});
    endfunction

    initial begin
        tri_exp = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F};

        // Sawtooth at step 0x10, then a mid-period retune to 0x2000, then two loads (last wins).
        addv(0, 1, 16'h1000, 8'h00, 2'b01, 8'h00, 0, 1);
        addv(0, 0, 16'h0000, 8'h00, 2'b00, 8'h00, 0, 0);
        for (int k = 0; k < 18; k++)
            addv(1, 0, 16'h0, 8'h0, 2'b00, 8'((k * 16) & 255), (k % 16) == 15, 0);
        addv(1, 1, 16'h2000, 8'h00, 2'b01, 8'h20, 0, 1);
        for (int k = 19; k < 31; k++)
            addv(1, 0, 16'h0, 8'h0, 2'b00, 8'((k * 16) & 255), 0, 1);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'hF0, 1, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h00, 0, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h20, 0, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h40, 0, 0);
        addv(1, 1, 16'h0800, 8'h00, 2'b01, 8'h60, 0, 1);
        addv(1, 1, 16'h4000, 8'h00, 2'b01, 8'h80, 0, 1);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'hA0, 0, 1);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'hC0, 0, 1);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'hE0, 1, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h00, 0, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h40, 0, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'h80, 0, 0);
        addv(1, 0, 16'h0, 8'h0, 2'b00, 8'hC0, 1, 0);

        do_reset();
        chk("reset_wave", 16'(bus.wave_out), 16'h00);
        chk("reset_wrap", 16'(bus.wrap), 16'h0);
        chk("reset_pending", 16'(bus.pending), 16'h0);

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].ld, vq[i].tw, vq[i].duty, vq[i].mode);
            tick();
            $display("vec %0d: en=%0b ld=%0b tw=%h wave=%h wrap=%0b pend=%0b", i, vq[i].en,
                     vq[i].ld, vq[i].tw, bus.wave_out, bus.wrap, bus.pending);
            chk($sformatf("tbl_wave[%0d]", i), 16'(bus.wave_out), 16'(vq[i].ew));
            chk($sformatf("tbl_wrap[%0d]", i), 16'(bus.wrap), 16'(vq[i].ewrap));
            chk($sformatf("tbl_pend[%0d]", i), 16'(bus.pending), 16'(vq[i].ep));
        end

        // Asynchronous reset with a pending set: outputs clear between clock edges.
        drive(1, 1, 16'h1000, 8'h00, 2'b01);
        tick();
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        tick();
        chk("pre_areset_wave", 16'(bus.wave_out), 16'h40);
        chk("pre_areset_pend", 16'(bus.pending), 16'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_wave", 16'(bus.wave_out), 16'h00);
        chk("areset_wrap", 16'(bus.wrap), 16'h0);
        chk("areset_pend", 16'(bus.pending), 16'h0);
        $display("async reset: wave=%h wrap=%0b pend=%0b", bus.wave_out, bus.wrap, bus.pending);
        tick();
        reset = 1'b0;

        // Zero active step: phase frozen, and a load applies on the very next cycle.
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_wrap", 16'(bus.wrap), 16'h0);
            chk("idle_wave", 16'(bus.wave_out), 16'h00);
        end
        drive(1, 1, 16'h1000, 8'h00, 2'b01);
        tick();
        chk("tw0_load_pend", 16'(bus.pending), 16'h1);
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        tick();
        chk("tw0_apply_pend", 16'(bus.pending), 16'h0);
        tick();
        chk("tw0_first_wave", 16'(bus.wave_out), 16'h00);
        tick();
        chk("tw0_second_wave", 16'(bus.wave_out), 16'h10);
        $display("tw0 apply: wave=%h pend=%0b", bus.wave_out, bus.pending);

        // Square 50% duty, load while disabled.
        do_reset();
        drive(0, 1, 16'h0100, 8'h80, 2'b00);
        tick();
        chk("sq_load_pend", 16'(bus.pending), 16'h1);
        drive(0, 0, 16'h0, 8'h0, 2'b00);
        tick();
        chk("sq_apply_pend", 16'(bus.pending), 16'h0);
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk($sformatf("sq_wave[%0d]", k), 16'(bus.wave_out),
                (((k - 1) % 256) < 128) ? 16'h00FF : 16'h0000);
            chk($sformatf("sq_wrap[%0d]", k), 16'(bus.wrap), 16'((k % 256) == 0));
        end
        $display("square run: 260 cycles, last wave=%h", bus.wave_out);

        // duty = 0 gives constant zero.
        do_reset();
        drive(0, 1, 16'h1000, 8'h00, 2'b00);
        tick();
        drive(0, 0, 16'h0, 8'h0, 2'b00);
        tick();
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("duty0_wave[%0d]", k), 16'(bus.wave_out), 16'h00);
        end
        $display("duty0 run: 40 cycles");

        // Triangle (or reserved behaviour when the triangle build option is off).
        do_reset();
        drive(0, 1, 16'h2000, 8'h00, 2'b10);
        tick();
        drive(0, 0, 16'h0, 8'h0, 2'b00);
        tick();
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        for (int k = 1; k <= 16; k++) begin
            tick();
`ifdef WAVE_TRIANGLE_EN
            chk($sformatf("tri_wave[%0d]", k), 16'(bus.wave_out), 16'(tri_exp[(k - 1) % 8]));
`else
            chk($sformatf("tri_off_wave[%0d]", k), 16'(bus.wave_out), 16'h00);
`endif
            chk($sformatf("tri_wrap[%0d]", k), 16'(bus.wrap), 16'((k % 8) == 0));
        end
        $display("triangle run: 16 cycles");

        // Reserved mode stays at zero.
        do_reset();
        drive(0, 1, 16'h1000, 8'hFF, 2'b11);
        tick();
        drive(0, 0, 16'h0, 8'h0, 2'b00);
        tick();
        drive(1, 0, 16'h0, 8'h0, 2'b00);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("rsvd_wave[%0d]", k), 16'(bus.wave_out), 16'h00);
        end
        $display("reserved run: 16 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Parametrised direct-digital-synthesis tone source; successor to the fixed square-wave generator. A phase accumulator driven by a tuning word produces square (programmable duty), sawtooth or triangle output at RESOLUTION_BITS amplitude. Settings are double-buffered and take effect only at a period boundary, so tone changes never glitch. It feeds the audio mixer/DAC path.

## Interface
- RESOLUTION_BITS, 8, output sample width; must be ≥ 2
- ACC_WIDTH, 16, phase accumulator width; must be > RESOLUTION_BITS
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = accumulator advances; 0 = accumulator frozen
- load  in  1  single-cycle strobe; captures tuning_word, duty, mode into the pending set
- tuning_word  in  ACC_WIDTH  phase increment per clk
- duty  in  RESOLUTION_BITS  square-wave high threshold
- mode  in  2  00 square, 01 sawtooth, 10 triangle, 11 reserved
- wave_out  out  RESOLUTION_BITS  registered sample
- wrap  out  1  one-cycle pulse, accumulator overflowed
- pending  out  1  a loaded setting set is waiting to be applied

## Operation
- Registers: acc, active set (tw_a, duty_a, mode_a), pending set plus pending flag.
- load=1: pending set ← inputs; pending ← 1. Later loads overwrite earlier ones (last wins).
- Apply pending (active ← pending, pending ← 0) in a cycle where pending=1 and any of these holds:
  - the accumulator overflows this cycle (carry out of acc + tw_a)
  - enable=0
  - tw_a=0
- load in an apply cycle: the old pending set is applied and the new values become pending. pending stays 1.
- enable=1: acc ← (acc + tw_a) mod 2^ACC_WIDTH. wrap ← carry out. tw_a=0 gives frozen phase and no wrap.
- enable=0: acc holds and wrap=0.
- phase = acc[ACC_WIDTH-1 -: RESOLUTION_BITS]. wave_out ← f(mode_a, phase) every cycle:
  - square: all-ones if phase < duty_a, else 0. duty 0 gives constant 0.
  - sawtooth: phase.
  - triangle: t = {phase[R-2:0],1'b0}. Output t if phase MSB=0, else ~t.
  - reserved: 0.

## Timing
- Reset values: acc=0, active and pending sets all 0, pending=0, wave_out=0, wrap=0.
- Reset is asynchronous mid-operation: all of the above clear immediately and any pending set is discarded.
- Latency: wave_out at edge n+1 = f(acc after edge n). One register stage.
- wrap asserts on the same edge as the wrapped acc value. The wave_out for that phase follows one cycle later.
- Applied settings affect acc's next increment and wave_out from the next edge.
- Output period = 2^ACC_WIDTH / tw_a clk cycles. Exact when tw_a is a power of two.

## Configuration
- WAVE_TRIANGLE_EN defined: mode 10 generates the triangle wave.
- WAVE_TRIANGLE_EN not defined: triangle logic is absent and mode 10 behaves as reserved (wave_out=0).
- All other behaviour is identical either way.

## Structure
- Shared package wave_pkg holds:
  - mode encodings MODE_SQUARE, MODE_SAW, MODE_TRI, MODE_RSVD
  - default widths
- One sub-module, phase_accumulator: acc register, add, carry/wrap and the enable freeze.
- Shadow registers, apply logic and waveform mapping stay in dds_wave_gen.

## Test plan
- Reset, defaults: assert reset mid-run with pending=1 -> wave_out, wrap, pending = 0 immediately. After release, acc stays 0 until load.
- Square: enable=0, load tw=0x0100, duty=0x80, mode=00, then enable=1 -> 128 cycles 0xFF, 128 cycles 0x00, wrap every 256 cycles.
- Sawtooth: tw=0x1000, mode=01 -> wave_out 0x00,0x10,…,0xF0 repeating, wrap every 16 cycles.
- Glitch-free update: running tw=0x1000, load tw=0x2000 mid-period -> pending=1. Step stays 0x10 until the wrap cycle, then 0x20 and pending=0. Two loads before wrap -> only the last is applied.
- Triangle, WAVE_TRIANGLE_EN defined: tw=0x2000, mode=10 -> 0x00,0x40,0x80,0xC0,0xFF,0xBF,0x7F,0x3F repeating. Same stimulus without the macro -> constant 0x00.
- Edge cases:
  - duty=0 -> constant 0
  - tw_a=0 with a pending load -> applied next cycle
  - load during enable=0 -> applied next cycle
